// File: rtl/cpu_alu_seq.sv
// Multi-cycle sequencer between the MCS8 decoder and the combinational ALU; owns ACC and CF/ZF/SF/PF.
// Optional memory-ack timeout abort: define CPU_ALU_SEQ_TIMEOUT_EN.
module cpu_alu_seq #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       CMD_VALID_I,
  output logic       CMD_READY_O,
  input  logic [3:0] CMD_SEL_I,
  input  logic [2:0] CMD_FUNC_I,
  input  logic       CMD_MEM_I,
  input  logic [7:0] CMD_REG_I,
  output logic       MEM_REQ_O,
  input  logic       MEM_ACK_I,
  input  logic [7:0] MEM_DATA_I,
  output logic [3:0] ALU_SEL_O,
  output logic [2:0] ALU_FUNC_O,
  output logic [7:0] ALU_A_O,
  output logic [7:0] ALU_B_O,
  output logic       ALU_CF_O,
  input  logic [7:0] ALU_E_I,
  input  logic       ALU_CF_I,
  input  logic       ALU_ZF_I,
  input  logic       ALU_SF_I,
  input  logic       ALU_PF_I,
  input  logic       ACC_WE_I,
  input  logic [7:0] ACC_DATA_I,
  output logic [7:0] ACC_O,
  output logic [3:0] FLAGS_O,
  output logic       RF_WE_O,
  output logic [7:0] RF_DATA_O,
  output logic       DONE_O,
  output logic       ERR_O
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] WB    = 2'd3;

  logic [1:0] state;
  logic [3:0] sel_q;
  logic [2:0] func_q;
  logic [7:0] a_q, b_q, e_q;
  logic [3:0] res_flags;
  logic [7:0] acc;
  logic       cf, zf, sf, pf;
  logic       accept;
  logic       timeout;
  logic [7:0] acc_eff;

  assign accept  = (state == IDLE) && CMD_VALID_I;
  assign acc_eff = ACC_WE_I ? ACC_DATA_I : acc;

`ifdef CPU_ALU_SEQ_TIMEOUT_EN
  logic [4:0] tmo_cnt;
  logic       err_q;

  assign timeout = (state == FETCH) && !MEM_ACK_I && (tmo_cnt == 5'(TIMEOUT_CYC - 1));
  assign ERR_O   = err_q;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= timeout;
      if (accept && CMD_MEM_I)
        tmo_cnt <= '0;
      else if (state == FETCH)
        tmo_cnt <= tmo_cnt + 5'd1;
    end
  end
`else
  assign timeout = 1'b0;
  // TIMEOUT_CYC only matters with the timeout build; referenced here so it is not dangling.
  assign ERR_O   = 1'b0 & (TIMEOUT_CYC != 0);
`endif

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state      <= IDLE;
      sel_q      <= '0;
      func_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      e_q        <= '0;
      res_flags  <= '0;
      acc        <= '0;
      {cf, zf, sf, pf} <= '0;
      ALU_SEL_O  <= '0;
      ALU_FUNC_O <= '0;
      ALU_A_O    <= '0;
      ALU_B_O    <= '0;
      ALU_CF_O   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ACC_WE_I)
            acc <= ACC_DATA_I;
          if (accept) begin
            sel_q  <= CMD_SEL_I;
            func_q <= CMD_FUNC_I;
            a_q    <= acc_eff;
            if (CMD_MEM_I) begin
              state <= FETCH;
            end else begin
              b_q        <= CMD_REG_I;
              ALU_SEL_O  <= CMD_SEL_I;
              ALU_FUNC_O <= CMD_FUNC_I;
              ALU_A_O    <= acc_eff;
              ALU_B_O    <= CMD_REG_I;
              ALU_CF_O   <= cf;
              state      <= EXEC;
            end
          end
        end
        FETCH: begin
          if (MEM_ACK_I) begin
            b_q        <= MEM_DATA_I;
            ALU_SEL_O  <= sel_q;
            ALU_FUNC_O <= func_q;
            ALU_A_O    <= a_q;
            ALU_B_O    <= MEM_DATA_I;
            ALU_CF_O   <= cf;
            state      <= EXEC;
          end else if (timeout) begin
            state <= IDLE;
          end
        end
        EXEC: begin
          e_q       <= ALU_E_I;
          res_flags <= {ALU_CF_I, ALU_ZF_I, ALU_SF_I, ALU_PF_I};
          state     <= WB;
        end
        default: begin
          // Commit happens on leaving WB so a reset during WB still drops the command.
          case (sel_q)
            4'b1000: begin
              if (func_q != 3'b111)
                acc <= e_q;
              {cf, zf, sf, pf} <= res_flags;
            end
            4'b0100: begin
              acc <= e_q;
              cf  <= res_flags[3];
            end
            4'b0010, 4'b0001: {zf, sf, pf} <= res_flags[2:0];
            default: ;
          endcase
          state <= IDLE;
        end
      endcase
    end
  end

  assign CMD_READY_O = (state == IDLE);
  assign MEM_REQ_O   = (state == FETCH);
  assign DONE_O      = (state == WB);
  assign RF_WE_O     = (state == WB) && ((sel_q == 4'b0010) || (sel_q == 4'b0001));
  assign RF_DATA_O   = e_q;
  assign ACC_O       = acc;
  assign FLAGS_O     = {cf, zf, sf, pf};

endmodule
